axi4_rr_interconnect: RTL and testbench
=======================================

// Module: axi4_rr_interconnect
// PURPOSE
//  Parametrised N-master -> 1-slave AXI4 interconnect in front of the DDR/frame-buffer slave.
//  Independent read and write round-robin arbiters; each grant is held for a whole burst.
//  Grants are generated internally, so no external state_r/state_w select is needed.
//  Beat counters check burst length against AxLEN and flag mismatches.
// PARAMETERS
//  NUM_M   4    number of masters, 2..8; master m occupies slice [m*W +: W] of each flattened bus
//  DATA_W  256  data width
//  ADDR_W  28   address width
//  ID_W    4    ID width; IDs pass through unchanged
//  LEN_W   4    AxLEN width; a burst is AxLEN+1 beats
// PORTS
//  clk        in   1             clock
//  rst_n      in   1             asynchronous reset, active low
//  m_arid/araddr/arlen/arvalid  in   NUM_M*{ID_W,ADDR_W,LEN_W,1}  read address, per master
//  m_arready  out  NUM_M         read address ready, per master
//  m_rid/rdata/rlast/rvalid     out  NUM_M*{ID_W,DATA_W,1,1}      read data, per master
//  m_rready   in   NUM_M         read data ready, per master
//  m_awid/awaddr/awlen/awvalid  in   NUM_M*{ID_W,ADDR_W,LEN_W,1}  write address, per master
//  m_awready  out  NUM_M         write address ready, per master
//  m_wdata/wlast/wvalid         in   NUM_M*{DATA_W,1,1}           write data, per master
//  m_wready   out  NUM_M         write data ready, per master
//  m_bvalid   out  NUM_M         write response valid;  m_bready in NUM_M: write response ready
//  s_ar*/s_aw*/s_w*  out  1x widths above  slave request side;  s_arready/s_awready/s_wready in 1
//  s_rid/rdata/rlast/rvalid  in  slave read data;  s_rready out 1;  s_bvalid in 1;  s_bready out 1
//  rd_grant   out  NUM_M         one-hot current read owner, 0 when idle
//  wr_grant   out  NUM_M         one-hot current write owner, 0 when idle
//  len_err    out  1             sticky: a burst's xLAST did not arrive on beat AxLEN+1
// BEHAVIOUR
//  Reset (async, rst_n=0): both FSMs IDLE; grants=0; both rr pointers=0; beat counters=0; len_err=0.
//   All READY/VALID outputs are 0 while in reset.
//  Read FSM: R_IDLE -> R_ADDR -> R_DATA -> R_IDLE.
//   R_IDLE: if any m_arvalid, grant the first requester at or after rr_ptr (wrapping modulo NUM_M).
//    Register rd_grant and enter R_ADDR.
//   R_ADDR: s_ar* = granted master's ar*; m_arready[g] = s_arready.
//    On s_arvalid & s_arready: latch arlen, clear beat count, enter R_DATA.
//   R_DATA: m_r*[g] = s_r*; s_rready = m_rready[g]; each accepted beat increments the count.
//    On a beat with s_rlast: enter R_IDLE, rr_ptr = g+1 (wrapping), clear rd_grant.
//  Write FSM: W_IDLE -> W_ADDR -> W_DATA -> W_RESP -> W_IDLE.
//   Arbitration is identical to the read FSM, using an independent wr_ptr.
//   W_DATA completes on s_wvalid & s_wready & s_wlast. W_RESP completes on s_bvalid & s_bready.
//   On W_RESP completion, wr_ptr = g+1.
//  Path muxing is combinational from the registered grant.
//   Earliest cycle: m_xVALID seen in IDLE -> s_xVALID driven the next cycle.
//  Non-granted masters: all READY/VALID = 0, all data/ID = 0.
//  With no grant, all slave-side VALID/READY outputs = 0 and data = 0.
//  A master may drop AxVALID before AxREADY. If that happens in R_ADDR/W_ADDR, return to IDLE with pointer unchanged.
//  len_err: set when xLAST arrives with count != AxLEN, or count reaches AxLEN without xLAST.
//   Cleared only by reset. The burst still completes on xLAST.
//  Simultaneous read and write: the two FSMs are fully independent; both may be granted in the same cycle.
//  Reset mid-burst: FSMs abort immediately to IDLE; the slave must be reset with the same rst_n.
// TESTING
//  1. NUM_M=4, m0..m3 raise arvalid together, each with arlen=3
//     -> grants 0,1,2,3 in order; each owner receives 4 beats, the last carrying rlast.
//  2. m2 holds arvalid continuously and m0 requests after m2's burst
//     -> m0 is granted next; m2 is not re-granted back-to-back.
//  3. Read by m1 and write by m3 start in the same cycle
//     -> rd_grant=0010 and wr_grant=1000 concurrently; m3 sees bvalid only after wlast.
//  4. Slave asserts rlast on beat 2 of an arlen=3 burst
//     -> len_err=1 and stays 1; the next burst is still granted normally.
//  5. rst_n pulled low during R_DATA with s_rvalid=1
//     -> all outputs 0 asynchronously; after release the first request goes to m0.
//  6. Slave holds wready=0 for 5 cycles mid-burst -> wdata is held stable and no beat is lost or duplicated.

Source files
------------

// File: rtl/axi4_rr_interconnect.sv
// N-master to 1-slave AXI4 interconnect with independent round-robin read and
// write arbiters. Each grant is held for a whole burst. Beat counters compare
// the burst against AxLEN and raise a sticky len_err on mismatch.
module axi4_rr_interconnect #(
  parameter int NUM_M  = 4,
  parameter int DATA_W = 256,
  parameter int ADDR_W = 28,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_M*ID_W-1:0]     m_arid,
  input  logic [NUM_M*ADDR_W-1:0]   m_araddr,
  input  logic [NUM_M*LEN_W-1:0]    m_arlen,
  input  logic [NUM_M-1:0]          m_arvalid,
  output logic [NUM_M-1:0]          m_arready,
  output logic [NUM_M*ID_W-1:0]     m_rid,
  output logic [NUM_M*DATA_W-1:0]   m_rdata,
  output logic [NUM_M-1:0]          m_rlast,
  output logic [NUM_M-1:0]          m_rvalid,
  input  logic [NUM_M-1:0]          m_rready,
  input  logic [NUM_M*ID_W-1:0]     m_awid,
  input  logic [NUM_M*ADDR_W-1:0]   m_awaddr,
  input  logic [NUM_M*LEN_W-1:0]    m_awlen,
  input  logic [NUM_M-1:0]          m_awvalid,
  output logic [NUM_M-1:0]          m_awready,
  input  logic [NUM_M*DATA_W-1:0]   m_wdata,
  input  logic [NUM_M-1:0]          m_wlast,
  input  logic [NUM_M-1:0]          m_wvalid,
  output logic [NUM_M-1:0]          m_wready,
  output logic [NUM_M-1:0]          m_bvalid,
  input  logic [NUM_M-1:0]          m_bready,
  output logic [ID_W-1:0]           s_arid,
  output logic [ADDR_W-1:0]         s_araddr,
  output logic [LEN_W-1:0]          s_arlen,
  output logic                      s_arvalid,
  input  logic                      s_arready,
  input  logic [ID_W-1:0]           s_rid,
  input  logic [DATA_W-1:0]         s_rdata,
  input  logic                      s_rlast,
  input  logic                      s_rvalid,
  output logic                      s_rready,
  output logic [ID_W-1:0]           s_awid,
  output logic [ADDR_W-1:0]         s_awaddr,
  output logic [LEN_W-1:0]          s_awlen,
  output logic                      s_awvalid,
  input  logic                      s_awready,
  output logic [DATA_W-1:0]         s_wdata,
  output logic                      s_wlast,
  output logic                      s_wvalid,
  input  logic                      s_wready,
  input  logic                      s_bvalid,
  output logic                      s_bready,
  output logic [NUM_M-1:0]          rd_grant,
  output logic [NUM_M-1:0]          wr_grant,
  output logic                      len_err
);

  localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} rd_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3} wr_state_t;

  // Returns {found, index} of the first requester at or after ptr, wrapping.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_M-1:0] req,
                                             input logic [IDX_W-1:0] ptr);
    logic [IDX_W:0] res;
    int p;
    res = '0;
    for (int k = NUM_M - 1; k >= 0; k--) begin
      p = int'(ptr) + k;
      if (p >= NUM_M) begin
        p = p - NUM_M;
      end else begin
        p = p;
      end
      if (req[p[IDX_W-1:0]]) begin
        res = {1'b1, p[IDX_W-1:0]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Pointer successor modulo NUM_M.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    if (i == IDX_W'(NUM_M - 1)) begin
      return '0;
    end else begin
      return i + 1'b1;
    end
  endfunction

  rd_state_t        rd_state_r, rd_state_s;
  wr_state_t        wr_state_r, wr_state_s;
  logic [IDX_W-1:0] rd_idx_r, rd_idx_s, rd_ptr_r, rd_ptr_s;
  logic [IDX_W-1:0] wr_idx_r, wr_idx_s, wr_ptr_r, wr_ptr_s;
  logic [LEN_W-1:0] rd_len_r, rd_len_s, rd_cnt_r, rd_cnt_s;
  logic [LEN_W-1:0] wr_len_r, wr_len_s, wr_cnt_r, wr_cnt_s;
  logic [NUM_M-1:0] rd_grant_s, wr_grant_s;
  logic [IDX_W:0]   rd_pick_s, wr_pick_s;
  logic             rd_err_s, wr_err_s;

  // Read arbiter: next state, grant, pointer and beat-count bookkeeping.
  always_comb begin
    rd_pick_s  = rr_pick(m_arvalid, rd_ptr_r);
    rd_state_s = rd_state_r;
    rd_idx_s   = rd_idx_r;
    rd_ptr_s   = rd_ptr_r;
    rd_len_s   = rd_len_r;
    rd_cnt_s   = rd_cnt_r;
    rd_grant_s = rd_grant;
    rd_err_s   = 1'b0;
    case (rd_state_r)
      R_IDLE: begin
        if (rd_pick_s[IDX_W]) begin
          rd_idx_s   = rd_pick_s[IDX_W-1:0];
          rd_grant_s = '0;
          rd_grant_s[rd_pick_s[IDX_W-1:0]] = 1'b1;
          rd_state_s = R_ADDR;
        end else begin
          rd_grant_s = '0;
        end
      end
      R_ADDR: begin
        if (!m_arvalid[rd_idx_r]) begin
          // Requester withdrew: release without advancing the pointer.
          rd_grant_s = '0;
          rd_state_s = R_IDLE;
        end else if (s_arready) begin
          rd_len_s   = m_arlen[rd_idx_r*LEN_W +: LEN_W];
          rd_cnt_s   = '0;
          rd_state_s = R_DATA;
        end else begin
          rd_state_s = R_ADDR;
        end
      end
      R_DATA: begin
        if (s_rvalid && m_rready[rd_idx_r]) begin
          rd_cnt_s = rd_cnt_r + 1'b1;
          rd_err_s = s_rlast ^ (rd_cnt_r == rd_len_r);
          if (s_rlast) begin
            rd_ptr_s   = next_idx(rd_idx_r);
            rd_grant_s = '0;
            rd_state_s = R_IDLE;
          end else begin
            rd_state_s = R_DATA;
          end
        end else begin
          rd_state_s = R_DATA;
        end
      end
      default: begin
        rd_grant_s = '0;
        rd_state_s = R_IDLE;
      end
    endcase
  end

  // Write arbiter: same scheme plus a response phase before release.
  always_comb begin
    wr_pick_s  = rr_pick(m_awvalid, wr_ptr_r);
    wr_state_s = wr_state_r;
    wr_idx_s   = wr_idx_r;
    wr_ptr_s   = wr_ptr_r;
    wr_len_s   = wr_len_r;
    wr_cnt_s   = wr_cnt_r;
    wr_grant_s = wr_grant;
    wr_err_s   = 1'b0;
    case (wr_state_r)
      W_IDLE: begin
        if (wr_pick_s[IDX_W]) begin
          wr_idx_s   = wr_pick_s[IDX_W-1:0];
          wr_grant_s = '0;
          wr_grant_s[wr_pick_s[IDX_W-1:0]] = 1'b1;
          wr_state_s = W_ADDR;
        end else begin
          wr_grant_s = '0;
        end
      end
      W_ADDR: begin
        if (!m_awvalid[wr_idx_r]) begin
          wr_grant_s = '0;
          wr_state_s = W_IDLE;
        end else if (s_awready) begin
          wr_len_s   = m_awlen[wr_idx_r*LEN_W +: LEN_W];
          wr_cnt_s   = '0;
          wr_state_s = W_DATA;
        end else begin
          wr_state_s = W_ADDR;
        end
      end
      W_DATA: begin
        if (m_wvalid[wr_idx_r] && s_wready) begin
          wr_cnt_s = wr_cnt_r + 1'b1;
          wr_err_s = m_wlast[wr_idx_r] ^ (wr_cnt_r == wr_len_r);
          if (m_wlast[wr_idx_r]) begin
            wr_state_s = W_RESP;
          end else begin
            wr_state_s = W_DATA;
          end
        end else begin
          wr_state_s = W_DATA;
        end
      end
      W_RESP: begin
        if (s_bvalid && m_bready[wr_idx_r]) begin
          wr_ptr_s   = next_idx(wr_idx_r);
          wr_grant_s = '0;
          wr_state_s = W_IDLE;
        end else begin
          wr_state_s = W_RESP;
        end
      end
      default: begin
        wr_grant_s = '0;
        wr_state_s = W_IDLE;
      end
    endcase
  end

  // Arbiter state registers; reset aborts any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_r <= R_IDLE;
      rd_idx_r   <= '0;
      rd_ptr_r   <= '0;
      rd_len_r   <= '0;
      rd_cnt_r   <= '0;
      rd_grant   <= '0;
      wr_state_r <= W_IDLE;
      wr_idx_r   <= '0;
      wr_ptr_r   <= '0;
      wr_len_r   <= '0;
      wr_cnt_r   <= '0;
      wr_grant   <= '0;
    end else begin
      rd_state_r <= rd_state_s;
      rd_idx_r   <= rd_idx_s;
      rd_ptr_r   <= rd_ptr_s;
      rd_len_r   <= rd_len_s;
      rd_cnt_r   <= rd_cnt_s;
      rd_grant   <= rd_grant_s;
      wr_state_r <= wr_state_s;
      wr_idx_r   <= wr_idx_s;
      wr_ptr_r   <= wr_ptr_s;
      wr_len_r   <= wr_len_s;
      wr_cnt_r   <= wr_cnt_s;
      wr_grant   <= wr_grant_s;
    end
  end

  // Sticky burst-length error, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_err <= 1'b0;
    end else if (rd_err_s || wr_err_s) begin
      len_err <= 1'b1;
    end else begin
      len_err <= len_err;
    end
  end

  // Read path mux: only the granted master sees the slave, only in its phase.
  always_comb begin
    s_arid    = '0;
    s_araddr  = '0;
    s_arlen   = '0;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    m_arready = '0;
    m_rid     = '0;
    m_rdata   = '0;
    m_rlast   = '0;
    m_rvalid  = '0;
    case (rd_state_r)
      R_ADDR: begin
        s_arid    = m_arid[rd_idx_r*ID_W +: ID_W];
        s_araddr  = m_araddr[rd_idx_r*ADDR_W +: ADDR_W];
        s_arlen   = m_arlen[rd_idx_r*LEN_W +: LEN_W];
        s_arvalid = m_arvalid[rd_idx_r];
        m_arready[rd_idx_r] = s_arready;
      end
      R_DATA: begin
        m_rid[rd_idx_r*ID_W +: ID_W]       = s_rid;
        m_rdata[rd_idx_r*DATA_W +: DATA_W] = s_rdata;
        m_rlast[rd_idx_r]  = s_rlast;
        m_rvalid[rd_idx_r] = s_rvalid;
        s_rready = m_rready[rd_idx_r];
      end
      default: begin
        s_rready = 1'b0;
      end
    endcase
  end

  // Write path mux: address, data and response phases of the granted master.
  always_comb begin
    s_awid    = '0;
    s_awaddr  = '0;
    s_awlen   = '0;
    s_awvalid = 1'b0;
    s_wdata   = '0;
    s_wlast   = 1'b0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    case (wr_state_r)
      W_ADDR: begin
        s_awid    = m_awid[wr_idx_r*ID_W +: ID_W];
        s_awaddr  = m_awaddr[wr_idx_r*ADDR_W +: ADDR_W];
        s_awlen   = m_awlen[wr_idx_r*LEN_W +: LEN_W];
        s_awvalid = m_awvalid[wr_idx_r];
        m_awready[wr_idx_r] = s_awready;
      end
      W_DATA: begin
        s_wdata  = m_wdata[wr_idx_r*DATA_W +: DATA_W];
        s_wlast  = m_wlast[wr_idx_r];
        s_wvalid = m_wvalid[wr_idx_r];
        m_wready[wr_idx_r] = s_wready;
      end
      W_RESP: begin
        m_bvalid[wr_idx_r] = s_bvalid;
        s_bready = m_bready[wr_idx_r];
      end
      default: begin
        s_bready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_axi4_rr_interconnect.sv
// Scoreboard bench for axi4_rr_interconnect: directed bursts push expected
// grants/beats/responses into queues; a negedge monitor pops and compares.
module tb_axi4_rr_interconnect;
  localparam int NM = 4, DATA_W = 256, ADDR_W = 28, ID_W = 4, LEN_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [NM*ID_W-1:0]   m_arid, m_awid, m_rid;
  logic [NM*ADDR_W-1:0] m_araddr, m_awaddr;
  logic [NM*LEN_W-1:0]  m_arlen, m_awlen;
  logic [NM*DATA_W-1:0] m_rdata, m_wdata;
  logic [NM-1:0] m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  logic [NM-1:0] m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [ID_W-1:0] s_arid, s_rid, s_awid;
  logic [ADDR_W-1:0] s_araddr, s_awaddr;
  logic [LEN_W-1:0] s_arlen, s_awlen;
  logic [DATA_W-1:0] s_rdata, s_wdata;
  logic s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
  logic s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [NM-1:0] rd_grant, wr_grant;
  logic len_err;

  axi4_rr_interconnect #(.NUM_M(NM), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bready(s_bready),
    .rd_grant(rd_grant), .wr_grant(wr_grant), .len_err(len_err)
  );

  always #5 clk = ~clk;

  typedef struct { int m; logic [ID_W-1:0] id; logic [DATA_W-1:0] data; logic last; } rexp_t;
  typedef struct { logic [DATA_W-1:0] data; logic last; } wexp_t;
  rexp_t exp_r[$];
  wexp_t exp_w[$];
  int    exp_rg[$], exp_wg[$], exp_b[$];

  int vectors = 0, miscompares = 0;
  logic ar_hold = 1'b0;
  int rd_short = -1, wr_stall_after = -1;
  logic wlast_seen = 1'b0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] wword(input logic [31:0] base, input int b);
    logic [31:0] w;
    w = base + 32'(b);
    return {(DATA_W/32){w}};
  endfunction

  task automatic push_rd(input int m, input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                         input int nbeats);
    rexp_t e;
    exp_rg.push_back(m);
    for (int b = 0; b < nbeats; b++) begin
      e.m = m; e.id = id; e.data = DATA_W'(addr) + DATA_W'(b); e.last = (b == nbeats - 1);
      exp_r.push_back(e);
    end
  endtask

  task automatic push_wr(input int m, input int len, input logic [31:0] base);
    wexp_t e;
    exp_wg.push_back(m);
    for (int b = 0; b <= len; b++) begin
      e.data = wword(base, b); e.last = (b == len);
      exp_w.push_back(e);
    end
    exp_b.push_back(m);
  endtask

  task automatic rd_req(input int m, input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr, input int len);
    int c;
    m_arid[m*ID_W +: ID_W] = id;
    m_araddr[m*ADDR_W +: ADDR_W] = addr;
    m_arlen[m*LEN_W +: LEN_W] = LEN_W'(len);
    m_arvalid[m] = 1'b1;
    for (c = 0; c < 300; c++) begin
      @(negedge clk);
      if (m_arready[m]) break;
    end
    if (c == 300) chk("ar_timeout", 256'd0, 256'd1);
    @(posedge clk); #1;
    m_arvalid[m] = 1'b0;
  endtask

  task automatic wr_req(input int m, input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                        input int len, input logic [31:0] base);
    int c;
    m_awid[m*ID_W +: ID_W] = id;
    m_awaddr[m*ADDR_W +: ADDR_W] = addr;
    m_awlen[m*LEN_W +: LEN_W] = LEN_W'(len);
    m_awvalid[m] = 1'b1;
    for (c = 0; c < 300; c++) begin
      @(negedge clk);
      if (m_awready[m]) break;
    end
    if (c == 300) chk("aw_timeout", 256'd0, 256'd1);
    @(posedge clk); #1;
    m_awvalid[m] = 1'b0;
    for (int b = 0; b <= len; b++) begin
      m_wdata[m*DATA_W +: DATA_W] = wword(base, b);
      m_wlast[m] = (b == len);
      m_wvalid[m] = 1'b1;
      for (c = 0; c < 300; c++) begin
        @(negedge clk);
        if (m_wready[m]) break;
      end
      if (c == 300) chk("w_timeout", 256'd0, 256'd1);
      @(posedge clk); #1;
    end
    m_wvalid[m] = 1'b0;
    m_wlast[m] = 1'b0;
  endtask

  task automatic wait_idle();
    int c;
    for (c = 0; c < 400; c++) begin
      @(negedge clk);
      if (exp_r.size() == 0 && exp_w.size() == 0 && exp_b.size() == 0 &&
          exp_rg.size() == 0 && exp_wg.size() == 0) break;
    end
    if (c == 400) chk("idle_timeout", 256'd0, 256'd1);
    @(negedge clk);
  endtask

  // Read slave responder: data beat b of a burst at address A is A+b.
  initial begin : rd_slave
    logic ar_f, r_f;
    logic [ADDR_W-1:0] a;
    logic [ID_W-1:0] id;
    logic [LEN_W-1:0] len;
    logic busy;
    int beat, stop;
    busy = 1'b0; beat = 0; a = '0; id = '0; len = '0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0; s_rdata = '0; s_rid = '0;
    forever begin
      @(negedge clk);
      ar_f = s_arvalid && s_arready;
      r_f  = s_rvalid && s_rready;
      if (ar_f) begin a = s_araddr; id = s_arid; len = s_arlen; end
      @(posedge clk); #1;
      if (!rst_n) begin
        busy = 1'b0; s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0; s_rdata = '0; s_rid = '0;
      end else begin
        if (ar_f) begin busy = 1'b1; beat = 0; end
        else if (r_f) begin
          if (s_rlast) busy = 1'b0; else beat++;
        end
        stop = (rd_short >= 0) ? rd_short : int'(len);
        s_arready = !busy && !ar_hold;
        s_rvalid  = busy;
        s_rdata   = busy ? DATA_W'(a) + DATA_W'(beat) : '0;
        s_rid     = id;
        s_rlast   = busy && (beat == stop);
      end
    end
  end

  // Write slave responder with optional wready stall after a given beat.
  initial begin : wr_slave
    logic aw_f, w_f, b_f, wl;
    int st, beats, stall;
    st = 0; beats = 0; stall = 0;
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0;
    forever begin
      @(negedge clk);
      aw_f = s_awvalid && s_awready;
      w_f  = s_wvalid && s_wready;
      b_f  = s_bvalid && s_bready;
      wl   = s_wlast;
      @(posedge clk); #1;
      if (!rst_n) begin
        st = 0; stall = 0; s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0;
      end else begin
        if (st == 0 && aw_f) begin st = 1; beats = 0; end
        else if (st == 1 && w_f) begin
          beats++;
          if (wl) st = 2;
          else if (beats == wr_stall_after + 1) stall = 5;
        end else if (st == 2 && b_f) st = 0;
        if (!w_f && stall > 0) stall--;
        s_awready = (st == 0);
        s_wready  = (st == 1) && (stall == 0);
        s_bvalid  = (st == 2);
      end
    end
  end

  // Monitor: pop and compare whenever the DUT presents a handshake.
  initial begin : monitor
    rexp_t re;
    wexp_t we;
    int g;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (s_arvalid && s_arready) begin
          if (exp_rg.size() == 0) chk("rd_grant_unexp", 256'(rd_grant), 256'd0);
          else begin g = exp_rg.pop_front(); chk("rd_grant", 256'(rd_grant), 256'(1 << g)); end
        end
        if (s_awvalid && s_awready) begin
          if (exp_wg.size() == 0) chk("wr_grant_unexp", 256'(wr_grant), 256'd0);
          else begin g = exp_wg.pop_front(); chk("wr_grant", 256'(wr_grant), 256'(1 << g)); end
        end
        for (int m = 0; m < NM; m++) begin
          if (m_rvalid[m] && m_rready[m]) begin
            if (exp_r.size() == 0) chk("r_unexp", 256'(m), 256'hFF);
            else begin
              re = exp_r.pop_front();
              chk("r_master", 256'(m), 256'(re.m));
              chk("r_data", m_rdata[m*DATA_W +: DATA_W], re.data);
              chk("r_id", 256'(m_rid[m*ID_W +: ID_W]), 256'(re.id));
              chk("r_last", 256'(m_rlast[m]), 256'(re.last));
            end
          end
        end
        if (s_wvalid && s_wready) begin
          if (exp_w.size() == 0) chk("w_unexp", s_wdata, 256'd0);
          else begin
            we = exp_w.pop_front();
            chk("w_data", s_wdata, we.data);
            chk("w_last", 256'(s_wlast), 256'(we.last));
            if (s_wlast) wlast_seen = 1'b1;
          end
        end else if (s_wvalid && exp_w.size() != 0) begin
          chk("w_hold", s_wdata, exp_w[0].data);
        end
        for (int m = 0; m < NM; m++) begin
          if (m_bvalid[m]) begin
            chk("b_after_wlast", 256'(wlast_seen), 256'd1);
            if (m_bready[m]) begin
              if (exp_b.size() == 0) chk("b_unexp", 256'(m), 256'hFF);
              else begin g = exp_b.pop_front(); chk("b_master", 256'(m), 256'(g)); end
              wlast_seen = 1'b0;
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int c;
    rst_n = 1'b0;
    m_arid = '0; m_araddr = '0; m_arlen = '0; m_arvalid = '0; m_rready = '1;
    m_awid = '0; m_awaddr = '0; m_awlen = '0; m_awvalid = '0;
    m_wdata = '0; m_wlast = '0; m_wvalid = '0; m_bready = '1;
    repeat (2) @(negedge clk);
    chk("rst_rd_grant", 256'(rd_grant), 256'd0);
    chk("rst_wr_grant", 256'(wr_grant), 256'd0);
    chk("rst_len_err", 256'(len_err), 256'd0);
    chk("rst_s_valid", 256'({s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready}), 256'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: all four request together, arlen=3 -> grants 0,1,2,3
    for (int m = 0; m < NM; m++) push_rd(m, ID_W'(m + 4), ADDR_W'(28'h0001000 * (m + 1)), 4);
    fork
      rd_req(0, 4'd4, 28'h0001000, 3);
      rd_req(1, 4'd5, 28'h0002000, 3);
      rd_req(2, 4'd6, 28'h0003000, 3);
      rd_req(3, 4'd7, 28'h0004000, 3);
    join
    wait_idle();

    // 2: m2 requests back to back, m0 joins -> 2,0,2
    push_rd(2, 4'd2, 28'h0000200, 2);
    push_rd(0, 4'd0, 28'h0000300, 3);
    push_rd(2, 4'd3, 28'h0000240, 2);
    fork
      begin rd_req(2, 4'd2, 28'h0000200, 1); rd_req(2, 4'd3, 28'h0000240, 1); end
      begin
        for (c = 0; c < 100; c++) begin @(negedge clk); if (rd_grant == 4'b0100) break; end
        if (c == 100) chk("t2_wait", 256'd0, 256'd1);
        rd_req(0, 4'd0, 28'h0000300, 2);
      end
    join
    wait_idle();

    // 3: concurrent read by m1 and write by m3
    push_rd(1, 4'd9, 28'h0000500, 2);
    push_wr(3, 1, 32'hA5A5_0000);
    fork
      rd_req(1, 4'd9, 28'h0000500, 1);
      wr_req(3, 4'd3, 28'h0000600, 1, 32'hA5A5_0000);
      begin
        @(negedge clk);
        chk("t3_rd_grant", 256'(rd_grant), 256'(4'b0010));
        chk("t3_wr_grant", 256'(wr_grant), 256'(4'b1000));
      end
    join
    wait_idle();

    // 4: rlast on beat 2 of an arlen=3 burst -> sticky len_err
    chk("t4_len_err_pre", 256'(len_err), 256'd0);
    rd_short = 1;
    push_rd(0, 4'd1, 28'h0000700, 2);
    rd_req(0, 4'd1, 28'h0000700, 3);
    wait_idle();
    rd_short = -1;
    chk("t4_len_err_set", 256'(len_err), 256'd1);
    push_rd(1, 4'd2, 28'h0000800, 1);
    rd_req(1, 4'd2, 28'h0000800, 0);
    wait_idle();
    chk("t4_len_err_hold", 256'(len_err), 256'd1);

    // 5: reset during R_DATA with s_rvalid=1
    m_rready[2] = 1'b0;
    exp_rg.push_back(2);
    rd_req(2, 4'd6, 28'h0000900, 3);
    repeat (2) @(negedge clk);
    chk("t5_rvalid_pre", 256'(m_rvalid), 256'(4'b0100));
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_rvalid", 256'(m_rvalid), 256'd0);
    chk("t5_rst_grants", 256'({rd_grant, wr_grant}), 256'd0);
    chk("t5_rst_len_err", 256'(len_err), 256'd0);
    chk("t5_rst_s_rready", 256'({s_rready, s_arvalid, m_arready}), 256'd0);
    exp_r.delete(); exp_rg.delete();
    m_rready = '1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_rd(0, 4'd0, 28'h0000A00, 1);
    push_rd(3, 4'd3, 28'h0000B00, 1);
    fork
      rd_req(0, 4'd0, 28'h0000A00, 0);
      rd_req(3, 4'd3, 28'h0000B00, 0);
    join
    wait_idle();

    // 6: slave stalls wready for 5 cycles mid-burst
    wr_stall_after = 1;
    push_wr(1, 3, 32'h1234_5600);
    wr_req(1, 4'd1, 28'h0000C00, 3, 32'h1234_5600);
    wait_idle();
    wr_stall_after = -1;

    // 7: arvalid withdrawn in R_ADDR leaves the pointer untouched
    push_rd(1, 4'd1, 28'h0000D00, 1);
    rd_req(1, 4'd1, 28'h0000D00, 0);
    wait_idle();
    ar_hold = 1'b1;
    m_araddr[3*ADDR_W +: ADDR_W] = 28'h0000E00;
    m_arvalid[3] = 1'b1;
    for (c = 0; c < 20; c++) begin @(negedge clk); if (rd_grant != 4'b0000) break; end
    chk("t7_grant_m3", 256'(rd_grant), 256'(4'b1000));
    @(negedge clk);
    m_arvalid[3] = 1'b0;
    @(negedge clk);
    chk("t7_released", 256'(rd_grant), 256'd0);
    ar_hold = 1'b0;
    push_rd(2, 4'd2, 28'h0000F00, 1);
    push_rd(0, 4'd0, 28'h0000F80, 1);
    fork
      rd_req(0, 4'd0, 28'h0000F80, 0);
      rd_req(2, 4'd2, 28'h0000F00, 0);
    join
    wait_idle();

    chk("queues_empty", 256'(exp_r.size() + exp_w.size() + exp_b.size() + exp_rg.size() + exp_wg.size()), 256'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
